// File: rtl/la_trig_pkg.sv
// Shared types and constants for the logic-analyzer protocol triggers.
package la_trig_pkg;

    // Receiver FSM states for the UART protocol trigger.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_trig_state_t;

    // Data bits in one 8N1 frame.
    localparam int UART_DATA_BITS = 8;

    // Flops between an asynchronous channel input and the clk domain.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/uart_prot_trig_if.sv
// Bus bundle for the UART protocol trigger: serial line, configuration
// registers, trigger/readback outputs and the FSM state for observation.
// The host side (master) drives RX and the registers.  The trigger side
// (slave) drives UARTtrig, rx_byte and dbg_state.  There is no
// valid/ready handshake: the registers are level configuration, and
// UARTtrig is a single-clk event pulse that carries no backpressure.
interface uart_prot_trig_if
    import la_trig_pkg::*;
#(
    parameter int BAUD_W = 16,
    parameter int DATA_W = UART_DATA_BITS
);
    logic              RX;
    logic [BAUD_W-1:0] baud_cnt;
    logic [DATA_W-1:0] match;
    logic [DATA_W-1:0] mask;
    logic              UARTtrig;
    logic [DATA_W-1:0] rx_byte;
    uart_trig_state_t  dbg_state;

    modport master (
        output RX, baud_cnt, match, mask,
        input  UARTtrig, rx_byte, dbg_state
    );

    modport slave (
        input  RX, baud_cnt, match, mask,
        output UARTtrig, rx_byte, dbg_state
    );
endinterface

// File: rtl/sync2_preset.sv
// Two-flop synchronizer with asynchronous preset to 1, so that an idle-high
// line (UART RX, SPI SS_n) reads as idle straight out of reset.
module sync2_preset #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/uart_prot_trig.sv
// UART (8N1) protocol trigger: decodes frames on the synchronized RX line
// using a programmable clocks-per-bit count and pulses UARTtrig for one clk
// when the received byte equals match on every bit not set in mask.
// Optional build macro UART_PROT_TRIG_FRAME_CHK_EN: when defined, a stop
// bit sampled as 0 is a framing error that suppresses the trigger and
// leaves rx_byte unchanged; when undefined, the stop bit value is ignored.
module uart_prot_trig
    import la_trig_pkg::*;
#(
    parameter int BAUD_W = 16,
    parameter int DATA_W = UART_DATA_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_prot_trig_if.slave bus
);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    uart_trig_state_t  r_state;
    logic [BAUD_W-1:0] r_baud_ctr;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_rx_byte;
    logic              r_trig;
    logic              r_rx_d;

    logic              w_rx_s;
    logic              w_fall;
    logic              w_hit;
    logic              w_ctr_zero;
    logic [BAUD_W-1:0] w_reload;

    sync2_preset #(.W(1)) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.RX),
        .o_q   (w_rx_s)
    );

    // Delayed copy of the synchronized line for start-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_d <= 1'b1;
        end else begin
            r_rx_d <= w_rx_s;
        end
    end

    assign w_fall     = r_rx_d & ~w_rx_s;
    assign w_ctr_zero = (r_baud_ctr == '0);
    assign w_reload   = bus.baud_cnt - BAUD_W'(1);
    // Masked compare is live on the shift register, so register writes land at the compare.
    assign w_hit      = (((r_shift ^ bus.match) & ~bus.mask) == '0);

    // Frame decoder: half-bit wait to mid start, then one full bit per sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_baud_ctr <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rx_byte  <= '0;
            r_trig     <= 1'b0;
        end else begin
            r_trig <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_baud_ctr <= bus.baud_cnt >> 1;
                        r_bit_cnt  <= '0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_ctr_zero) begin
                        // A line already back high at mid start bit was a glitch.
                        if (w_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_baud_ctr <= w_reload;
                            r_state    <= DATA;
                        end
                    end else begin
                        r_baud_ctr <= r_baud_ctr - BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (w_ctr_zero) begin
                        r_shift    <= {w_rx_s, r_shift[DATA_W-1:1]};
                        r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
                        r_baud_ctr <= w_reload;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_baud_ctr <= r_baud_ctr - BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (w_ctr_zero) begin
                        r_state <= IDLE;
`ifdef UART_PROT_TRIG_FRAME_CHK_EN
                        if (w_rx_s) begin
                            r_rx_byte <= r_shift;
                            r_trig    <= w_hit;
                        end
`else
                        r_rx_byte <= r_shift;
                        r_trig    <= w_hit;
`endif
                    end else begin
                        r_baud_ctr <= r_baud_ctr - BAUD_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.UARTtrig  = r_trig;
    assign bus.rx_byte   = r_rx_byte;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_uart_prot_trig.sv
// Bench for uart_prot_trig: drives 8N1 frames bit by bit, predicts trigger
// and readback from the matching rule, and counts every trigger pulse.
module tb_uart_prot_trig;
    import la_trig_pkg::*;

    localparam int BAUD_W = 16;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Clock and reset
    always #5 clk = ~clk;

    uart_prot_trig_if #(.BAUD_W(BAUD_W), .DATA_W(DATA_W)) bus();

    uart_prot_trig #(.BAUD_W(BAUD_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    longint       cyc = 0;
    longint       start_cyc = 0;
    longint       last_trig_cyc = 0;
    int           trig_count = 0;
    logic         trig_prev = 1'b0;
    logic [7:0]   exp_q[$];
    logic [7:0]   exp_rx_byte = 8'h00;

    always @(posedge clk) cyc++;

    // Scoreboard: every trigger pulse must be one clk wide and carry an expected byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.UARTtrig === 1'b1) begin
                trig_count++;
                last_trig_cyc = cyc;
                n_checks++;
                if (trig_prev === 1'b1) begin
                    n_fail++;
                    $display("FAIL trig_width: UARTtrig high for 2+ consecutive clks at cycle %0d", cyc);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_trig: trigger with rx_byte=%02h, none expected", bus.rx_byte);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (bus.rx_byte !== e) begin
                        n_fail++;
                        $display("FAIL trig_byte: rx_byte=%02h at trigger, expected %02h", bus.rx_byte, e);
                    end
                end
            end
            trig_prev = bus.UARTtrig;
        end else begin
            trig_prev = 1'b0;
        end
    end

    // Reference model: masked equality, gated by the stop bit when frame check is built in.
    function automatic logic frame_ok(input logic stop_bit);
`ifdef UART_PROT_TRIG_FRAME_CHK_EN
        return stop_bit;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic frame_hits(input logic [7:0] d, input logic [7:0] m,
                                        input logic [7:0] k, input logic stop_bit);
        int diff;
        diff = 0;
        for (int i = 0; i < 8; i++) begin
            if (!k[i] && (d[i] != m[i])) diff++;
        end
        return (diff == 0) && frame_ok(stop_bit);
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Driver: start bit, 8 data bits LSB first, stop bit; each bit lasts baud clks.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int baud);
        bus.RX = 1'b0;
        start_cyc = cyc;
        repeat (baud) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.RX = d[i];
            repeat (baud) @(negedge clk);
        end
        bus.RX = stop_bit;
        repeat (baud) @(negedge clk);
        bus.RX = 1'b1;
    endtask

    // Driver plus prediction for one frame; returns how many triggers it produced.
    task automatic run_frame(input logic [7:0] d, input logic stop_bit, input int baud,
                             output int n_trig, output int exp_trig);
        int t0;
        t0 = trig_count;
        exp_trig = frame_hits(d, bus.match, bus.mask, stop_bit) ? 1 : 0;
        if (exp_trig == 1) exp_q.push_back(d);
        if (frame_ok(stop_bit)) exp_rx_byte = d;
        bus.baud_cnt = BAUD_W'(baud);
        send_frame(d, stop_bit, baud);
        wait_clks(3);
        n_trig = trig_count - t0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wait_clks(3);
        n_checks++;
        if (bus.UARTtrig !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_trig: UARTtrig=%b, expected 0", bus.UARTtrig);
        end
        n_checks++;
        if (bus.rx_byte !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rx_byte: rx_byte=%02h, expected 00", bus.rx_byte);
        end
        n_checks++;
        if (bus.dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d, expected IDLE", bus.dbg_state);
        end
        rst_n = 1'b1;
        wait_clks(5);
    endtask

    task automatic test_match;
        int n, e;
        longint lat;
        bus.match = 8'h96;
        bus.mask  = 8'h00;
        run_frame(8'h96, 1'b1, 868, n, e);
        n_checks++;
        if (n != 1) begin
            n_fail++;
            $display("FAIL match_count: %0d triggers, expected 1", n);
        end
        lat = last_trig_cyc - start_cyc;
        n_checks++;
        if (lat < 8248 || lat > 8252) begin
            n_fail++;
            $display("FAIL match_latency: %0d clks from start edge, expected 8250 +/-2", lat);
        end
        n_checks++;
        if (bus.rx_byte !== 8'h96) begin
            n_fail++;
            $display("FAIL match_rx_byte: rx_byte=%02h, expected 96", bus.rx_byte);
        end
    endtask

    task automatic test_mismatch;
        int n, e;
        run_frame(8'h97, 1'b1, 868, n, e);
        n_checks++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL mismatch_count: %0d triggers, expected 0", n);
        end
        n_checks++;
        if (bus.rx_byte !== 8'h97) begin
            n_fail++;
            $display("FAIL mismatch_rx_byte: rx_byte=%02h, expected 97", bus.rx_byte);
        end
    endtask

    task automatic test_masked;
        int n, e;
        bus.match = 8'hF0;
        bus.mask  = 8'h0F;
        run_frame(8'hF6, 1'b1, 32, n, e);
        n_checks++;
        if (n != 1) begin
            n_fail++;
            $display("FAIL masked_hit: %0d triggers for F6, expected 1", n);
        end
        run_frame(8'h76, 1'b1, 32, n, e);
        n_checks++;
        if (n != 0) begin
            n_fail++;
            $display("FAIL masked_miss: %0d triggers for 76, expected 0", n);
        end
        n_checks++;
        if (bus.rx_byte !== 8'h76) begin
            n_fail++;
            $display("FAIL masked_rx_byte: rx_byte=%02h, expected 76", bus.rx_byte);
        end
    endtask

    task automatic test_glitch;
        int t0;
        bus.baud_cnt = 16'd868;
        bus.match = 8'h00;
        bus.mask  = 8'hFF;
        t0 = trig_count;
        bus.RX = 1'b0;
        wait_clks(300);
        bus.RX = 1'b1;
        wait_clks(600);
        n_checks++;
        if (bus.dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL glitch_state: state=%0d, expected IDLE", bus.dbg_state);
        end
        n_checks++;
        if (trig_count != t0) begin
            n_fail++;
            $display("FAIL glitch_trig: %0d triggers, expected 0", trig_count - t0);
        end
        n_checks++;
        if (bus.rx_byte !== exp_rx_byte) begin
            n_fail++;
            $display("FAIL glitch_rx_byte: rx_byte=%02h, expected %02h", bus.rx_byte, exp_rx_byte);
        end
    endtask

    task automatic test_back_to_back;
        int t0;
        bus.baud_cnt = 16'd24;
        bus.mask = 8'hFF;
        t0 = trig_count;
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h69);
        exp_rx_byte = 8'h69;
        send_frame(8'h96, 1'b1, 24);
        send_frame(8'h69, 1'b1, 24);
        wait_clks(3);
        n_checks++;
        if (trig_count - t0 != 2) begin
            n_fail++;
            $display("FAIL b2b_count: %0d triggers, expected 2", trig_count - t0);
        end
        n_checks++;
        if (bus.rx_byte !== 8'h69) begin
            n_fail++;
            $display("FAIL b2b_rx_byte: rx_byte=%02h, expected 69", bus.rx_byte);
        end
    endtask

    task automatic test_framing;
        int n, e;
        bus.match = 8'h96;
        bus.mask  = 8'h00;
        run_frame(8'h96, 1'b0, 20, n, e);
        wait_clks(25);
        n_checks++;
        if (n != e) begin
            n_fail++;
            $display("FAIL framing_trig: %0d triggers with stop=0, expected %0d", n, e);
        end
        n_checks++;
        if (bus.rx_byte !== exp_rx_byte) begin
            n_fail++;
            $display("FAIL framing_rx_byte: rx_byte=%02h, expected %02h", bus.rx_byte, exp_rx_byte);
        end
    endtask

    task automatic test_reset_mid_frame;
        int n, e;
        logic [7:0] partial;
        partial = 8'hA5;
        bus.baud_cnt = 16'd20;
        bus.match = 8'hA5;
        bus.mask  = 8'h00;
        bus.RX = 1'b0;
        wait_clks(20);
        for (int i = 0; i < 3; i++) begin
            bus.RX = partial[i];
            wait_clks(20);
        end
        rst_n = 1'b0;
        exp_rx_byte = 8'h00;
        wait_clks(2);
        n_checks++;
        if (bus.UARTtrig !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_trig: UARTtrig=%b, expected 0", bus.UARTtrig);
        end
        n_checks++;
        if (bus.dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL midrst_state: state=%0d, expected IDLE", bus.dbg_state);
        end
        bus.RX = 1'b1;
        wait_clks(2);
        rst_n = 1'b1;
        wait_clks(5);
        run_frame(8'hA5, 1'b1, 20, n, e);
        n_checks++;
        if (n != 1) begin
            n_fail++;
            $display("FAIL midrst_next: %0d triggers on clean frame, expected 1", n);
        end
        n_checks++;
        if (bus.rx_byte !== 8'hA5) begin
            n_fail++;
            $display("FAIL midrst_rx_byte: rx_byte=%02h, expected A5", bus.rx_byte);
        end
    endtask

    task automatic test_random;
        int n, e, baud;
        logic [7:0] d, r;
        for (int k = 0; k < 20; k++) begin
            baud = $urandom_range(40, 16);
            bus.match = 8'($urandom);
            bus.mask  = 8'($urandom & $urandom);
            r = 8'($urandom);
            if ($urandom_range(1, 0) == 1) d = (bus.match & ~bus.mask) | (r & bus.mask);
            else d = r;
            run_frame(d, 1'b1, baud, n, e);
            n_checks++;
            if (n != e) begin
                n_fail++;
                $display("FAIL rand_trig[%0d]: d=%02h m=%02h k=%02h got %0d triggers, expected %0d",
                         k, d, bus.match, bus.mask, n, e);
            end
            n_checks++;
            if (bus.rx_byte !== exp_rx_byte) begin
                n_fail++;
                $display("FAIL rand_rx_byte[%0d]: rx_byte=%02h, expected %02h", k, bus.rx_byte, exp_rx_byte);
            end
            wait_clks($urandom_range(2 * baud, 0));
        end
    endtask

    initial begin
        bus.RX = 1'b1;
        bus.baud_cnt = 16'd868;
        bus.match = 8'h00;
        bus.mask = 8'h00;
        test_reset();
        test_match();
        test_mismatch();
        test_masked();
        test_glitch();
        test_back_to_back();
        test_framing();
        test_reset_mid_frame();
        test_random();
        wait_clks(5);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_trig: %0d expected triggers never seen", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
